// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over
// back-to-back windows of GATE_CYCLES clocks and publishes each count.
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             ovf,
  output logic             busy
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t              state;
  logic                s1, s2, s3;
  logic                rise;
  logic                arm_cnt;
  logic [GATE_W-1:0]   gate_cnt;
  logic [CNT_W-1:0]    edge_cnt;
  logic                sat;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic             inc);
    if (inc && (cnt != CNT_MAX)) return cnt + 1'b1;
    return cnt;
  endfunction

  function automatic logic sat_drop(input logic [CNT_W-1:0] cnt,
                                    input logic             inc);
    return inc && (cnt == CNT_MAX);
  endfunction

  // Input stage: two-flop synchronizer plus one delayed sample for edge detect
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  // Control and counting stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      arm_cnt    <= 1'b0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq       <= '0;
      freq_valid <= 1'b0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          arm_cnt  <= 1'b0;
          if (en) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          // two cycles let any edge left in the synchronizer drain uncounted
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            arm_cnt <= ~arm_cnt;
            if (arm_cnt) begin
              state    <= MEASURE;
              gate_cnt <= '0;
              edge_cnt <= '0;
              sat      <= 1'b0;
            end
          end
        end
        MEASURE: begin
          if (!en) begin
            state    <= IDLE;
            busy     <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else if (gate_cnt == GATE_LAST) begin
            // a rise on the final cycle still belongs to the ending window
            freq       <= sat_inc(edge_cnt, rise);
            ovf        <= sat | sat_drop(edge_cnt, rise);
            freq_valid <= 1'b1;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= sat_inc(edge_cnt, rise);
            sat      <= sat | sat_drop(edge_cnt, rise);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
